mem_datos_arb: RTL
==================

MEM_DATOS_ARB -- requirements
Module: mem_datos_arb

Interface
REQ-001 SHALL have port CLK  input  1  single system clock; all state updates on rising edge.
REQ-002 SHALL have port RST_N  input  1  reset, synchronous, active-low.
REQ-003 SHALL have ports REQ0 / REQ1  input  1  access request from port 0 (core load/store) / port 1 (loader/debug).
REQ-004 SHALL have ports ADDR0 / ADDR1  input  32  word address of request.
REQ-005 SHALL have ports WDATA0 / WDATA1  input  32  store data.
REQ-006 SHALL have ports WE0 / WE1  input  1  1 = store, 0 = load.
REQ-007 SHALL have ports GNT0 / GNT1  output  1  one-cycle pulse: request accepted and operands latched.
REQ-008 SHALL have ports DONE0 / DONE1  output  1  one-cycle pulse: transaction complete.
REQ-009 SHALL have ports RDATA0 / RDATA1  output  32  load result; valid while DONEx=1, held until next DONEx.
REQ-010 SHALL have port ALUResult  output  32  memory address to data memory.
REQ-011 SHALL have port WriteData  output  32  memory store data.
REQ-012 SHALL have port Write_EN  output  1  memory write enable.
REQ-013 SHALL have port Read_Data  input  32  memory read data, combinational from ALUResult.

Function
REQ-014 SHALL implement states IDLE, ACCESS, RESP; reset state IDLE.
REQ-015 IDLE: SHALL arbitrate among asserted REQx; on winner, SHALL latch ADDRx/WDATAx/WEx and port id, pulse GNTx, go ACCESS; with no request, SHALL stay IDLE.
REQ-016 ACCESS: SHALL drive ALUResult/WriteData from latched values, Write_EN = latched WE, capture Read_Data at cycle end, go RESP.
REQ-017 RESP: SHALL pulse DONEx of served port, update RDATAx only if load, go IDLE.
REQ-018 Latency SHALL be fixed: GNT in cycle t, memory access t+1, DONE t+2; peak throughput one transaction per 3 cycles.
REQ-019 Simultaneous REQ0 and REQ1 SHALL grant port not served last (round-robin); last-served pointer SHALL reset to port 1 so port 0 wins first tie.
REQ-020 Single requester SHALL be granted regardless of pointer; pointer SHALL update only on grant.
REQ-021 Requester SHALL hold REQx and operands stable until GNTx; REQx dropped before GNTx SHALL be treated as withdrawn with no access.
REQ-022 REQx high during ACCESS/RESP SHALL be ignored until IDLE; REQx still high in IDLE after its DONEx SHALL be a new request.
REQ-023 Write_EN SHALL be 1 only in ACCESS with latched WE=1; never in IDLE or RESP.
REQ-024 ALUResult and WriteData SHALL be 0 outside ACCESS.
REQ-025 At most one of GNT0/GNT1 and at most one of DONE0/DONE1 SHALL be high in any cycle.

Reset
REQ-026 RST_N=0 at a rising edge SHALL force IDLE, pointer=1, GNTx=DONEx=0, RDATAx=0, latched operands=0; outputs SHALL show these values from the following cycle.
REQ-027 Reset during ACCESS SHALL abort the transaction: no DONEx issued; a store whose Write_EN was high at that edge MAY complete in memory.
REQ-028 Requests asserted while RST_N=0 SHALL be ignored; arbitration SHALL resume first cycle with RST_N=1.

Configuration
REQ-029 Macro MEM_ARB_FIXED_PRIO_EN defined: port 0 SHALL win every tie; pointer unused.
REQ-030 Macro MEM_ARB_FIXED_PRIO_EN undefined: round-robin per REQ-019 SHALL apply.

Verification
REQ-031 Reset, no requests, 5 cycles -> all outputs 0, Write_EN=0.
REQ-032 REQ0 store ADDR0=1, WDATA0=2; then REQ0 load ADDR0=1 -> GNT0 t, Write_EN=1 at t+1 with ALUResult=1, DONE0 t+2; load DONE0 with RDATA0=2.
REQ-033 REQ0 and REQ1 both load from first post-reset cycle, held -> grant order 0,1,0,1; with MEM_ARB_FIXED_PRIO_EN -> 0,0,0.
REQ-034 REQ1 store ADDR1=3, WDATA1=4 while REQ0 idle; then REQ0 load ADDR0=3 -> RDATA0=4; RDATA1 unchanged (0).
REQ-035 REQ1 store granted, RST_N=0 in ACCESS cycle -> no DONE1, state IDLE next cycle, Write_EN=0 after reset edge.
REQ-036 REQ0 pulsed high one cycle during RESP of port-1 transaction then low -> no GNT0, no memory access.

Source files
------------

// File: rtl/mem_datos_arb.sv
// Two-port arbiter in front of a single-ported data memory: IDLE -> ACCESS -> RESP per transaction.
// Define MEM_ARB_FIXED_PRIO_EN for fixed port-0 priority; by default ties are resolved round-robin.
module mem_datos_arb #(
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              REQ0,
  input  logic              REQ1,
  input  logic [DATA_W-1:0] ADDR0,
  input  logic [DATA_W-1:0] ADDR1,
  input  logic [DATA_W-1:0] WDATA0,
  input  logic [DATA_W-1:0] WDATA1,
  input  logic              WE0,
  input  logic              WE1,
  output logic              GNT0,
  output logic              GNT1,
  output logic              DONE0,
  output logic              DONE1,
  output logic [DATA_W-1:0] RDATA0,
  output logic [DATA_W-1:0] RDATA1,
  output logic [DATA_W-1:0] ALUResult,
  output logic [DATA_W-1:0] WriteData,
  output logic              Write_EN,
  input  logic [DATA_W-1:0] Read_Data
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t            state;
  logic              gnt0_c;
  logic              gnt1_c;
  logic              port_p1;
  logic              we_p1;
  logic [DATA_W-1:0] addr_p1;
  logic [DATA_W-1:0] wdata_p1;
  logic [1:0]        done_p2;
`ifdef MEM_ARB_FIXED_PRIO_EN
`else
  logic              last_port;
`endif

  // Grant is decided inside the IDLE cycle so the access follows on the next cycle.
  always_comb begin
    gnt0_c = 1'b0;
    gnt1_c = 1'b0;
    if (RST_N && (state == IDLE)) begin
      if (REQ0 && REQ1) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
        gnt0_c = 1'b1;
`else
        gnt0_c = last_port;
        gnt1_c = !last_port;
`endif
      end else begin
        gnt0_c = REQ0;
        gnt1_c = REQ1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state    <= IDLE;
      port_p1  <= 1'b0;
      we_p1    <= 1'b0;
      addr_p1  <= '0;
      wdata_p1 <= '0;
      done_p2  <= 2'b00;
      RDATA0   <= '0;
      RDATA1   <= '0;
`ifdef MEM_ARB_FIXED_PRIO_EN
`else
      last_port <= 1'b1;
`endif
    end else begin
      done_p2 <= 2'b00;
      case (state)
        // p1: operands of the winning port latched at grant
        IDLE: begin
          if (gnt0_c || gnt1_c) begin
            port_p1  <= gnt1_c;
            we_p1    <= gnt1_c ? WE1 : WE0;
            addr_p1  <= gnt1_c ? ADDR1 : ADDR0;
            wdata_p1 <= gnt1_c ? WDATA1 : WDATA0;
`ifdef MEM_ARB_FIXED_PRIO_EN
`else
            last_port <= gnt1_c;
`endif
            state    <= ACCESS;
          end
        end
        // p2: load data captured so it is already visible alongside DONE
        ACCESS: begin
          if (!we_p1) begin
            if (port_p1) RDATA1 <= Read_Data;
            else         RDATA0 <= Read_Data;
          end
          done_p2 <= port_p1 ? 2'b10 : 2'b01;
          state   <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign GNT0      = gnt0_c;
  assign GNT1      = gnt1_c;
  assign DONE0     = done_p2[0];
  assign DONE1     = done_p2[1];
  assign ALUResult = (state == ACCESS) ? addr_p1 : '0;
  assign WriteData = (state == ACCESS) ? wdata_p1 : '0;
  assign Write_EN  = (state == ACCESS) && we_p1;

endmodule
